// File: rtl/ordena8_seq_ctrl.sv
// Sequential 8-element odd-even transposition sorter: LOAD 8 elements, 8 SORT passes, UNLOAD in order.
// Build option ORDENA8_DESCEND_EN flips the compare so the set unloads in descending order.

module ordena8_cas #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             en_i,
  output logic             swap_o
);
`ifdef ORDENA8_DESCEND_EN
  assign swap_o = en_i && (a_i < b_i);
`else
  // Strict compare: equal elements stay in place.
  assign swap_o = en_i && (a_i > b_i);
`endif
endmodule

module ordena8_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);
  localparam int NUM_LANES = 8;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_SORT   = 2'd1;
  localparam logic [1:0] ST_UNLOAD = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] load_cnt_q, load_cnt_d;
  logic [2:0] pass_cnt_q, pass_cnt_d;
  logic [2:0] out_idx_q, out_idx_d;
  logic [NUM_LANES-1:0][WIDTH-1:0] r_q, r_d;
  logic [NUM_LANES-2:0] swap;
  logic sort_st, in_fire, out_fire;

  assign sort_st   = (state_q == ST_SORT);
  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_UNLOAD);
  assign busy      = (state_q != ST_LOAD);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = out_valid ? r_q[out_idx_q] : '0;
  assign out_last  = out_valid && (out_idx_q == 3'd7);

  // One comparator per adjacent pair; pass parity selects even or odd pairs.
  for (genvar i = 0; i < NUM_LANES-1; i++) begin : g_cas
    localparam logic ODD = ((i % 2) == 1);
    ordena8_cas #(.WIDTH(WIDTH)) u_cas (
      .a_i    (r_q[i]),
      .b_i    (r_q[i+1]),
      .en_i   (sort_st && (pass_cnt_q[0] == ODD)),
      .swap_o (swap[i])
    );
  end

  always_comb begin
    r_d = r_q;
    if (in_fire) begin
      r_d[load_cnt_q] = in_data;
    end
    // Active pairs in one pass never overlap, so swaps are independent.
    for (int i = 0; i < NUM_LANES-1; i++) begin
      if (swap[i]) begin
        r_d[i]   = r_q[i+1];
        r_d[i+1] = r_q[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    pass_cnt_d = pass_cnt_q;
    out_idx_d  = out_idx_q;
    case (state_q)
      ST_LOAD: begin
        if (in_fire) begin
          load_cnt_d = load_cnt_q + 3'd1;
          if (load_cnt_q == 3'd7) begin
            state_d    = ST_SORT;
            pass_cnt_d = 3'd0;
          end
        end
      end
      ST_SORT: begin
        pass_cnt_d = pass_cnt_q + 3'd1;
        if (pass_cnt_q == 3'd7) begin
          state_d    = ST_UNLOAD;
          out_idx_d  = 3'd0;
          pass_cnt_d = 3'd0;
        end
      end
      ST_UNLOAD: begin
        if (out_fire) begin
          out_idx_d = out_idx_q + 3'd1;
          if (out_idx_q == 3'd7) begin
            state_d    = ST_LOAD;
            load_cnt_d = 3'd0;
            out_idx_d  = 3'd0;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      load_cnt_q <= 3'd0;
      pass_cnt_q <= 3'd0;
      out_idx_q  <= 3'd0;
      r_q        <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      out_idx_q  <= out_idx_d;
      r_q        <= r_d;
    end
  end

endmodule

// File: tb/tb_ordena8_seq_ctrl.sv
// Scoreboard bench for ordena8_seq_ctrl: directed sets with hand-sorted expectations.
module tb_ordena8_seq_ctrl;
  typedef logic [7:0] set_t [8];
  typedef struct packed { logic [7:0] data; logic last; } exp_t;

  logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [7:0] in_data, out_data;

  exp_t sbq[$];
  int   n_cmp = 0, n_bad = 0, hs_cnt = 0, tgt = 0;
  logic stall = 1'b0, hl = 1'b0;
  logic [7:0] hd = '0;

  ordena8_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected set is given ascending; descending build unloads it reversed.
  task automatic push_set(input set_t s);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
`ifdef ORDENA8_DESCEND_EN
      e.data = s[7-i];
`else
      e.data = s[i];
`endif
      e.last = (i == 7);
      sbq.push_back(e);
    end
    tgt += 8;
  endtask

  task automatic load_n(input set_t s, input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = s[i];
      k = 0;
      while (!in_ready && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      if (k == 100) check("in_ready_timeout", 32'(k), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_latency(input string nm);
    int n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check(nm, 32'(n), 8);
  endtask

  task automatic wait_hs(input string nm);
    int k = 0;
    while (hs_cnt < tgt && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check(nm, 32'(hs_cnt), 32'(tgt));
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_out_valid"}, 32'(out_valid), 0);
    check({nm, "_out_last"},  32'(out_last), 0);
    check({nm, "_out_data"},  32'(out_data), 0);
    check({nm, "_busy"},      32'(busy), 0);
    check({nm, "_in_ready"},  32'(in_ready), 1);
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall && out_valid) begin
        check("stall_hold_data", 32'(out_data), 32'(hd));
        check("stall_hold_last", 32'(out_last), 32'(hl));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %0h expected no output", out_data);
        end else begin
          e = sbq.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_last", 32'(out_last), 32'(e.last));
        end
        hs_cnt++;
      end
      stall = out_valid && !out_ready;
      hd    = out_data;
      hl    = out_last;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    set_t s_in, s_exp, s_b, s_bexp;
    int pat[4];
    int k, bad_ir;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Mixed set, free-running consumer
    s_in  = '{8'h50, 8'h10, 8'h70, 8'h30, 8'h80, 8'h20, 8'h60, 8'h40};
    s_exp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    push_set(s_exp); load_n(s_in, 8); check_latency("lat_mixed"); wait_hs("hs_mixed");

    // Worst case: strictly descending input
    s_in  = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA, 8'hF9, 8'hF8};
    s_exp = '{8'hF8, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    push_set(s_exp); load_n(s_in, 8); check_latency("lat_desc"); wait_hs("hs_desc");

    // Duplicates and extremes
    s_in  = '{8'h05, 8'h05, 8'h00, 8'h05, 8'h00, 8'hFF, 8'h00, 8'h05};
    s_exp = '{8'h00, 8'h00, 8'h00, 8'h05, 8'h05, 8'h05, 8'h05, 8'hFF};
    push_set(s_exp); load_n(s_in, 8); check_latency("lat_dup"); wait_hs("hs_dup");

    // Consumer stalls with pattern 1,0,0,1
    pat = '{1, 0, 0, 1};
    s_in  = '{8'h3C, 8'hA5, 8'h01, 8'hFE, 8'h77, 8'h88, 8'h12, 8'h9A};
    s_exp = '{8'h01, 8'h12, 8'h3C, 8'h77, 8'h88, 8'h9A, 8'hA5, 8'hFE};
    push_set(s_exp); load_n(s_in, 8); check_latency("lat_stall");
    k = 0;
    while (hs_cnt < tgt && k < 200) begin
      out_ready = pat[k % 4][0];
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("hs_stall_total", 32'(hs_cnt), 32'(tgt));

    // Second set held on the input during SORT/UNLOAD
    s_in   = '{8'h50, 8'h10, 8'h70, 8'h30, 8'h80, 8'h20, 8'h60, 8'h40};
    s_exp  = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    s_b    = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    s_bexp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    push_set(s_exp); load_n(s_in, 8);
    in_valid = 1'b1; in_data = s_b[0];
    bad_ir = 0; k = 0;
    while (hs_cnt < tgt && k < 200) begin
      if (in_ready) bad_ir++;
      @(posedge clk); #1;
      k++;
    end
    check("in_ready_low_while_busy", 32'(bad_ir), 0);
    check("hs_held_first", 32'(hs_cnt), 32'(tgt));
    check("in_ready_after_last", 32'(in_ready), 1);
    push_set(s_bexp); load_n(s_b, 8); check_latency("lat_second"); wait_hs("hs_second");

    // Reset after 4 loads discards the partial set
    load_n(s_in, 4);
    rst_n = 1'b0; #1;
    check_reset_outputs("rst_load");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    s_in  = '{8'hC3, 8'h11, 8'h7E, 8'h42, 8'h99, 8'h00, 8'h5D, 8'hE0};
    s_exp = '{8'h00, 8'h11, 8'h42, 8'h5D, 8'h7E, 8'h99, 8'hC3, 8'hE0};
    push_set(s_exp); load_n(s_in, 8); check_latency("lat_after_rst"); wait_hs("hs_after_rst");

    // Reset during SORT pass 3 produces no output
    load_n(s_in, 8);
    repeat (3) @(posedge clk);
    #2;
    check("busy_in_sort", 32'(busy), 1);
    rst_n = 1'b0; #1;
    check_reset_outputs("rst_sort");
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("no_output_after_sort_rst", 32'(hs_cnt), 32'(tgt));
    s_in  = '{8'h50, 8'h10, 8'h70, 8'h30, 8'h80, 8'h20, 8'h60, 8'h40};
    s_exp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    push_set(s_exp); load_n(s_in, 8); check_latency("lat_after_sort_rst"); wait_hs("hs_after_sort_rst");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
